priority_rr_arbiter: RTL and testbench
======================================

PRIORITY_RR_ARBITER -- requirements
Module: priority_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, number of requesters; SHALL be at least 2.
REQ-002 Parameter MAX_HOLD, default 16, maximum cycles one owner may hold the grant; SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 req  input  WIDTH  request vector; bit i high means requester i wants the resource.
REQ-006 done  input  1  current owner releases the resource this cycle.
REQ-007 grant  output  WIDTH  one-hot grant vector, registered.
REQ-008 grant_valid  output  1  high while any grant bit is high, registered.
REQ-009 grant_id  output  $clog2(WIDTH)  binary index of the current owner, registered; 0 when grant_valid is low.
REQ-010 timeout  output  1  one-cycle pulse when an owner is forcibly released by the hold limit.

Function
REQ-011 The block SHALL have two states: IDLE (no owner) and BUSY (one owner holds grant).
REQ-012 The block SHALL hold a round-robin pointer ptr, width $clog2(WIDTH), range 0..WIDTH-1.
REQ-013 Selection: the winner SHALL be the lowest index i >= ptr with req[i]=1; if none exists, the lowest index i >= 0 with req[i]=1.
REQ-014 IDLE with any req bit high: on the next edge, the state SHALL become BUSY, grant SHALL become one-hot at the winner, grant_id SHALL equal the winner, and grant_valid SHALL be 1. Latency from request to grant is 1 cycle.
REQ-015 IDLE with req all zero: outputs SHALL stay cleared and ptr SHALL be unchanged.
REQ-016 BUSY: grant, grant_id and grant_valid SHALL hold constant regardless of other req bits.
REQ-017 Release in BUSY SHALL occur when done=1, when req[grant_id]=0, or when the hold counter reaches MAX_HOLD-1.
REQ-018 On release: on the next edge, grant SHALL be cleared, grant_valid SHALL be 0, grant_id SHALL be 0, ptr SHALL become (grant_id+1) mod WIDTH, and the state SHALL become IDLE.
REQ-019 Every handover SHALL include one idle cycle between successive grants; back-to-back grants to different owners SHALL be separated by exactly one cycle with grant_valid=0.
REQ-020 The hold counter SHALL clear on entry to BUSY and increment each BUSY cycle without release.
REQ-021 A hold-limit release SHALL assert timeout for exactly the cycle in which grant_valid falls; timeout SHALL be 0 at all other times.
REQ-022 If done or req[grant_id]=0 occurs in the same cycle the counter reaches MAX_HOLD-1, the release is a normal release and timeout SHALL remain 0.
REQ-023 ptr wrap-around: grant_id=WIDTH-1 released SHALL set ptr=0.
REQ-024 done asserted in IDLE SHALL be ignored.
REQ-025 grant SHALL never have more than one bit set.

Reset
REQ-026 While rst_n=0, asynchronously: state=IDLE, grant=0, grant_valid=0, grant_id=0, timeout=0, ptr=0, and hold counter=0.
REQ-027 When rst_n is asserted mid-BUSY, grant SHALL be dropped immediately without waiting for a clock edge; the first arbitration after rst_n deasserts SHALL use ptr=0.

Verification
REQ-028 Reset, then req=8'b1000_0100 -> 1 cycle later grant=8'b0000_0100, grant_id=2; done pulse -> grant=0 next cycle, ptr=3.
REQ-029 ptr=3, req=8'b1000_0100 held -> next grant is grant_id=7; after release ptr wraps to 0 and the following grant is grant_id=2.
REQ-030 MAX_HOLD=16, owner 5 holds req without done -> grant drops after 16 BUSY cycles with timeout=1 for one cycle; grant_id=5 must not be selected first in the next arbitration if another request is pending.
REQ-031 Owner 1 drops req[1] without done -> release next cycle, timeout=0; while BUSY, other req toggles leave grant unchanged.
REQ-032 rst_n pulled low while BUSY with grant_id=4 -> grant=0 asynchronously; after rst_n rises with req=8'hFF -> grant_id=0.
REQ-033 Random req/done stimulus for at least 10k cycles -> grant is always one-hot or zero, grant_valid equals |grant, and every continuously requesting index is granted within WIDTH grants.

Source files
------------

// File: rtl/priority_rr_arbiter.sv
// Round-robin arbiter: one owner at a time, one idle cycle between owners,
// and a forced release (with a timeout pulse) once an owner hits MAX_HOLD cycles.
module priority_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req,
    input  logic                     done,
    output logic [WIDTH-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(WIDTH)-1:0] grant_id,
    output logic                     timeout
);
    localparam int IW = $clog2(WIDTH);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [IW-1:0] LAST_ID   = IW'(WIDTH - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IW-1:0]    id_q, id_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] req_upper;
    logic [IW-1:0]    winner;
    logic             hold_limit;
    logic             owner_release;

    // Winner search: lowest requester at or above ptr, else lowest overall.
    always_comb begin
        req_upper = req & ~((WIDTH'(1) << ptr_q) - WIDTH'(1));
        winner    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) winner = IW'(i);
        end
        if (|req_upper) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req_upper[i]) winner = IW'(i);
            end
        end
    end

    assign hold_limit    = (hold_q == HOLD_LAST);
    assign owner_release = done | ~req[id_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    grant_d = WIDTH'(1) << winner;
                    id_d    = winner;
                    hold_d  = '0;
                end
            end
            BUSY: begin
                if (owner_release || hold_limit) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    id_d      = '0;
                    ptr_d     = (id_q == LAST_ID) ? '0 : id_q + IW'(1);
                    hold_d    = '0;
                    // A voluntary release in the limit cycle is not a timeout.
                    timeout_d = ~owner_release;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant       = grant_q;
        grant_valid = (state_q == BUSY);
        grant_id    = id_q;
        timeout     = timeout_q;
    end

endmodule

// File: tb/tb_priority_rr_arbiter.sv
// Self-checking bench: directed vector table, hand-written hold-limit and
// async-reset sequences, then random traffic against a behavioural model.
module tb_priority_rr_arbiter;
    localparam int W  = 8;
    localparam int MH = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] req;
    logic         done;
    logic [W-1:0] grant;
    logic         grant_valid;
    logic [2:0]   grant_id;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    priority_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [W-1:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_valid", 32'(grant_valid), 32'h0);
        check("reset_id", 32'(grant_id), 32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
    endtask

    // Behavioural model: owner index (-1 = none), rotating start, busy-cycle count.
    int          m_owner;
    int          m_ptr;
    int          m_cycles;
    logic        m_to;

    function automatic int pick(input logic [W-1:0] r, input int p);
        int res = -1;
        for (int k = W - 1; k >= 0; k--) begin
            if (r[(p + k) % W]) res = (p + k) % W;
        end
        return res;
    endfunction

    task automatic model_step(input logic [W-1:0] r, input logic d);
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (r != '0) begin
                m_owner  = pick(r, m_ptr);
                m_cycles = 1;
            end
        end else if (d || !r[m_owner]) begin
            m_ptr   = (m_owner + 1) % W;
            m_owner = -1;
        end else if (m_cycles == MH) begin
            m_ptr   = (m_owner + 1) % W;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_cycles++;
        end
    endtask

    typedef struct packed {
        logic [W-1:0] req;
        logic         done;
        logic [W-1:0] grant;
        logic [2:0]   id;
        logic         valid;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [W-1:0] req_r;
        logic         d;
        logic [W-1:0] exp_grant;
        logic [2:0]   exp_id;
        logic         prev_valid;
        int           waiting[W];
        int           o;

        rst_n = 1'b1;
        req   = '0;
        done  = 1'b0;

        vecs[0]  = '{8'h84, 1'b0, 8'h04, 3'd2, 1'b1};
        vecs[1]  = '{8'h84, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[2]  = '{8'h84, 1'b0, 8'h80, 3'd7, 1'b1};
        vecs[3]  = '{8'h84, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[4]  = '{8'h84, 1'b0, 8'h04, 3'd2, 1'b1};
        vecs[5]  = '{8'h84, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[6]  = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1};
        vecs[7]  = '{8'hFE, 1'b0, 8'h02, 3'd1, 1'b1};
        vecs[8]  = '{8'h55, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[9]  = '{8'h55, 1'b0, 8'h04, 3'd2, 1'b1};
        vecs[10] = '{8'h51, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[11] = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1};
        vecs[12] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[13] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[14] = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1};
        vecs[15] = '{8'h01, 1'b1, 8'h00, 3'd0, 1'b0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            tick(vecs[i].req, vecs[i].done);
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
            check($sformatf("vec%0d_id", i), 32'(grant_id), 32'(vecs[i].id));
            check($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'h0);
        end

        // Hold limit: owner 5 keeps requesting, requester 3 waits behind it.
        tick(8'h20, 1'b0);
        check("hold_first_grant", 32'(grant), 32'h20);
        for (int k = 1; k < MH; k++) begin
            tick(8'h28, 1'b0);
            check($sformatf("hold_keep%0d", k), 32'({grant, timeout}), 32'({8'h20, 1'b0}));
        end
        tick(8'h28, 1'b0);
        check("hold_drop_grant", 32'(grant), 32'h0);
        check("hold_drop_timeout", 32'(timeout), 32'h1);
        tick(8'h28, 1'b0);
        check("hold_next_id", 32'(grant_id), 32'd3);
        check("hold_timeout_cleared", 32'(timeout), 32'h0);

        // done arriving in the limit cycle is an ordinary release.
        for (int k = 1; k < MH; k++) begin
            tick(8'h28, 1'b0);
        end
        check("limit_done_still_owned", 32'(grant), 32'h08);
        tick(8'h28, 1'b1);
        check("limit_done_grant", 32'(grant), 32'h0);
        check("limit_done_timeout", 32'(timeout), 32'h0);

        // Asynchronous reset while owner 4 holds the grant.
        do_reset();
        tick(8'h10, 1'b0);
        check("areset_pre_id", 32'(grant_id), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_grant_dropped", 32'(grant), 32'h0);
        check("areset_valid_dropped", 32'(grant_valid), 32'h0);
        tick(8'hFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("areset_after_id", 32'(grant_id), 32'd0);
        check("areset_after_grant", 32'(grant), 32'h01);

        // Random traffic against the model.
        do_reset();
        m_owner    = -1;
        m_ptr      = 0;
        m_cycles   = 0;
        m_to       = 1'b0;
        req_r      = '0;
        prev_valid = 1'b0;
        for (int i = 0; i < W; i++) waiting[i] = 0;
        for (int c = 0; c < 12000; c++) begin
            for (int i = 0; i < W; i++) begin
                if (req_r[i]) begin
                    if ($urandom_range(15) == 0) req_r[i] = 1'b0;
                end else if ($urandom_range(7) == 0) begin
                    req_r[i] = 1'b1;
                end
            end
            d = ($urandom_range(9) == 0);
            tick(req_r, d);
            model_step(req_r, d);
            exp_grant = (m_owner >= 0) ? W'(1) << m_owner : '0;
            exp_id    = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
            check("rand_outputs", 32'({grant, grant_id, grant_valid, timeout}),
                  32'({exp_grant, exp_id, (m_owner >= 0), m_to}));
            check("rand_onehot", 32'($onehot0(grant)), 32'h1);
            check("rand_valid_or", 32'(grant_valid), 32'(|grant));
            for (int i = 0; i < W; i++) begin
                if (!req_r[i]) waiting[i] = 0;
            end
            if (grant_valid && !prev_valid) begin
                o = int'(grant_id);
                waiting[o] = 0;
                for (int i = 0; i < W; i++) begin
                    if (i != o && req_r[i]) begin
                        waiting[i]++;
                        check($sformatf("rand_fair%0d", i), 32'(waiting[i] < W), 32'h1);
                    end
                end
            end
            prev_valid = grant_valid;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
